// File: rtl/sel2_pkg.sv
// Shared encodings for the sel2_arb arbiter: FSM states and selector polarity.
package sel2_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GA   = 2'd1,
        S_GB   = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/beat_cnt.sv
// Beat counter for one grant: synchronous clear (priority over enable), count
// enable, and a terminal flag raised when the next counted beat reaches BURST_MAX.
module beat_cnt #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count itself never reaches BURST_MAX: the beat that would get it there ends the grant.
    assign term = (cnt_q == CNT_W'(BURST_MAX - 1));
    assign cnt  = cnt_q;

endmodule

// File: rtl/sel2_arb.sv
// Two-requester round-robin arbiter driving SEL2_1.SEL, with bounded bursts,
// zero-bubble handover and fully registered outputs.
module sel2_arb
    import sel2_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic             ACK,
    output logic             SEL,
    output logic             VALID,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic [CNT_W-1:0] BEAT_CNT
);

    state_e state_q, state_d;
    logic   last_q,  last_d;
    logic   sel_q,   sel_d;
    logic   valid_q, valid_d;
    logic   gnt_a_q, gnt_a_d;
    logic   gnt_b_q, gnt_b_d;

    logic   req_own;
    logic   req_other;
    logic   own_side;
    logic   accept;
    logic   burst_done;
    logic   cnt_clr;
    logic   cnt_term;

    beat_cnt #(
        .BURST_MAX (BURST_MAX),
        .CNT_W     (CNT_W)
    ) u_beat_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr),
        .en   (accept),
        .cnt  (BEAT_CNT),
        .term (cnt_term)
    );

    assign own_side   = (state_q == S_GB) ? SEL_B : SEL_A;
    assign req_own    = (state_q == S_GB) ? REQ_B : REQ_A;
    assign req_other  = (state_q == S_GB) ? REQ_A : REQ_B;
    assign accept     = valid_q & ACK & req_own;
    assign burst_done = accept & cnt_term;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_clr = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (REQ_A && (!REQ_B || last_q == SEL_B)) begin
                    state_d = S_GA;
                end else if (REQ_B) begin
                    state_d = S_GB;
                end
            end
            S_GA, S_GB: begin
                if (!req_own || burst_done) begin
                    cnt_clr = 1'b1;
                    last_d  = own_side;
                    if (req_other) begin
                        state_d = (state_q == S_GA) ? S_GB : S_GA;
                    end else if (burst_done) begin
                        state_d = state_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered; SEL holds through IDLE.
    always_comb begin
        sel_d   = sel_q;
        valid_d = (state_d != S_IDLE);
        gnt_a_d = (state_d == S_GA);
        gnt_b_d = (state_d == S_GB);
        if (state_d == S_GA) begin
            sel_d = SEL_A;
        end else if (state_d == S_GB) begin
            sel_d = SEL_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= SEL_B;
            sel_q   <= SEL_A;
            valid_q <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    assign SEL   = sel_q;
    assign VALID = valid_q;
    assign GNT_A = gnt_a_q;
    assign GNT_B = gnt_b_q;

endmodule

// File: tb/tb_sel2_arb.sv
// Directed bench for sel2_arb: BURST_MAX=4 instance for burst/handover/reset
// scenarios, BURST_MAX=1 instance for per-beat alternation.
module tb_sel2_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       ack;

    logic       sel4, valid4, gnt_a4, gnt_b4;
    logic [2:0] cnt4;
    logic       sel1, valid1, gnt_a1, gnt_b1;
    logic [0:0] cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sel2_arb #(.BURST_MAX(4)) u_dut4 (
        .CLK      (clk),
        .RST      (rst),
        .REQ_A    (req_a),
        .REQ_B    (req_b),
        .ACK      (ack),
        .SEL      (sel4),
        .VALID    (valid4),
        .GNT_A    (gnt_a4),
        .GNT_B    (gnt_b4),
        .BEAT_CNT (cnt4)
    );

    sel2_arb #(.BURST_MAX(1)) u_dut1 (
        .CLK      (clk),
        .RST      (rst),
        .REQ_A    (req_a),
        .REQ_B    (req_b),
        .ACK      (ack),
        .SEL      (sel1),
        .VALID    (valid1),
        .GNT_A    (gnt_a1),
        .GNT_B    (gnt_b1),
        .BEAT_CNT (cnt1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the BURST_MAX=4 instance against {gnt_a, gnt_b, valid, sel, cnt}.
    task automatic expect4(input string tag, input logic ga, input logic gb,
                           input logic v, input logic s, input int c);
        check({tag, ".gnt_a"}, int'(gnt_a4), int'(ga));
        check({tag, ".gnt_b"}, int'(gnt_b4), int'(gb));
        check({tag, ".valid"}, int'(valid4), int'(v));
        check({tag, ".sel"},   int'(sel4),   int'(s));
        check({tag, ".cnt"},   int'(cnt4),   c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Mutual exclusion of the grants on both instances, every cycle out of reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("mutex4", int'(gnt_a4 & gnt_b4), 0);
            check("mutex1", int'(gnt_a1 & gnt_b1), 0);
        end
    end

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ack = 1'b0;

        // 1: single requester A, bursts of 4 then regrant with cleared count
        tick();
        expect4("rst_state", 0, 0, 0, 0, 0);
        rst = 1'b0; req_a = 1'b1; ack = 1'b1;
        tick();
        expect4("a_start", 1, 0, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            expect4($sformatf("a_beat%0d", i), 1, 0, 1, 0, i);
        end
        tick();
        expect4("a_regrant", 1, 0, 1, 0, 0);

        // 2: both requesting from reset, alternate 4-beat bursts with no VALID gap
        req_b = 1'b1;
        do_reset();
        expect4("tie_rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            expect4($sformatf("alt%0d", i), ((i / 4) % 2) == 0, ((i / 4) % 2) == 1,
                    1, ((i / 4) % 2) == 1, i % 4);
        end

        // 3: grant B with ACK low holds indefinitely, then completes the burst
        req_a = 1'b0; req_b = 1'b1; ack = 1'b0;
        do_reset();
        tick();
        expect4("b_start", 0, 1, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect4($sformatf("b_stall%0d", i), 0, 1, 1, 1, 0);
        end
        ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect4($sformatf("b_beat%0d", i), 0, 1, 1, 1, i);
        end
        tick();
        expect4("b_regrant", 0, 1, 1, 1, 0);

        // 4: REQ_A drops after 2 beats; ACK in drop cycle is not counted, SEL held
        req_a = 1'b1; req_b = 1'b0; ack = 1'b1;
        do_reset();
        tick();
        expect4("drop_start", 1, 0, 1, 0, 0);
        tick();
        tick();
        expect4("drop_2beats", 1, 0, 1, 0, 2);
        req_a = 1'b0;
        tick();
        expect4("drop_idle", 0, 0, 0, 0, 0);
        tick();
        expect4("drop_idle2", 0, 0, 0, 0, 0);

        // 5: reset mid-burst in GRANT_B, then a tie goes to A
        req_b = 1'b1;
        tick();
        expect4("mid_bstart", 0, 1, 1, 1, 0);
        tick();
        tick();
        expect4("mid_b2", 0, 1, 1, 1, 2);
        rst = 1'b1;
        tick();
        expect4("mid_rst", 0, 0, 0, 0, 0);
        rst = 1'b0; req_a = 1'b1;
        tick();
        expect4("post_rst_tie", 1, 0, 1, 0, 0);

        // 6: BURST_MAX=1 alternates every accepted beat
        do_reset();
        check("b1_rst_gnt_a", int'(gnt_a1), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("b1_gnt_a%0d", i), int'(gnt_a1), int'((i % 2) == 0));
            check($sformatf("b1_gnt_b%0d", i), int'(gnt_b1), int'((i % 2) == 1));
            check($sformatf("b1_sel%0d", i),   int'(sel1),   int'((i % 2) == 1));
            check($sformatf("b1_cnt%0d", i),   int'(cnt1),   0);
        end

        req_a = 1'b0; req_b = 1'b0; ack = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
